// File: rtl/cache_pkg.sv
// Shared cache definitions: geometry derivations, AXI encodings and writeback FSM states.
package cache_pkg;

  // Default cache geometry
  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int LINE_WIDTH_DEF  = 6;
  localparam int CACHE_WIDTH_DEF = 6;

  // Word select width within a line (32-bit words, 4 bytes each)
  function automatic int index_width(input int line_w);
    return line_w - 2;
  endfunction

  // Tag bits left after the set index and the line offset
  function automatic int tag_width(input int addr_w, input int line_w, input int cache_w);
    return addr_w - line_w - cache_w;
  endfunction

  localparam int INDEX_WIDTH = index_width(LINE_WIDTH_DEF);
  localparam int TAG_WIDTH   = tag_width(ADDR_WIDTH_DEF, LINE_WIDTH_DEF, CACHE_WIDTH_DEF);
  localparam int WORDS       = 1 << INDEX_WIDTH;

  // AXI encodings
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wb_state_t;

endpackage

// File: rtl/cache_line_writeback.sv
// Writeback engine: streams one dirty cache line out as a single AXI INCR write burst
// and reports completion (and any error response) back to the cache controller.
module cache_line_writeback
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_WIDTH  = 6,
  parameter int CACHE_WIDTH = 6
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wb_start,
  input  logic [ADDR_WIDTH-LINE_WIDTH-CACHE_WIDTH-1:0] wb_tag,
  input  logic [CACHE_WIDTH-1:0]                      wb_line,
  output logic                                        wb_busy,
  output logic                                        wb_done,
  output logic                                        wb_error,
  output logic [LINE_WIDTH-3:0]                       line_index,
  input  logic [DATA_WIDTH-1:0]                       line_data,
  output logic                                        awvalid,
  input  logic                                        awready,
  output logic [ADDR_WIDTH-1:0]                       awaddr,
  output logic [7:0]                                  awlen,
  output logic [2:0]                                  awsize,
  output logic [1:0]                                  awburst,
  output logic                                        wvalid,
  input  logic                                        wready,
  output logic [DATA_WIDTH-1:0]                       wdata,
  output logic [3:0]                                  wstrb,
  output logic                                        wlast,
  input  logic                                        bvalid,
  output logic                                        bready,
  input  logic [1:0]                                  bresp
);

  localparam int                    IDX_W    = index_width(LINE_WIDTH);
  localparam int                    N_WORDS  = 1 << IDX_W;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_WORDS - 1);

  wb_state_t state;

  // Fixed burst shape: whole line, 4-byte beats, incrementing, all lanes written
  assign awlen   = 8'(N_WORDS - 1);
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign wstrb   = 4'b1111;

  // Line storage read is combinational, so write data is the storage word for the current index
  assign wdata = line_data;

  // Writeback FSM with the word counter doubling as the storage index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      awvalid    <= 1'b0;
      awaddr     <= '0;
      wvalid     <= 1'b0;
      wlast      <= 1'b0;
      bready     <= 1'b0;
      wb_busy    <= 1'b0;
      wb_done    <= 1'b0;
      wb_error   <= 1'b0;
      line_index <= '0;
    end else begin
      wb_done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse still belongs to the finished writeback
          if (wb_start && !wb_done) begin
            awaddr     <= {wb_tag, wb_line, {LINE_WIDTH{1'b0}}};
            line_index <= '0;
            awvalid    <= 1'b1;
            wb_busy    <= 1'b1;
            wb_error   <= 1'b0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // wready is ignored here: the first beat is only offered after the AW handshake
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wlast   <= (line_index == LAST_IDX);
            state   <= DATA;
          end
        end
        DATA: begin
          if (wready) begin
            if (line_index == LAST_IDX) begin
              wvalid     <= 1'b0;
              wlast      <= 1'b0;
              bready     <= 1'b1;
              line_index <= '0;
              state      <= RESP;
            end else begin
              line_index <= line_index + 1'b1;
              wlast      <= ((line_index + 1'b1) == LAST_IDX);
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            bready   <= 1'b0;
            wb_done  <= 1'b1;
            wb_error <= (bresp != RESP_OKAY);
            wb_busy  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Randomized bench for cache_line_writeback with a burst-level reference model.
module tb_cache_line_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_start;
  logic [19:0] wb_tag;
  logic [5:0]  wb_line;
  logic        wb_busy, wb_done, wb_error;
  logic [3:0]  line_index;
  logic [31:0] line_data;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  cache_line_writeback dut (
    .clk(clk), .rst(rst), .wb_start(wb_start), .wb_tag(wb_tag), .wb_line(wb_line),
    .wb_busy(wb_busy), .wb_done(wb_done), .wb_error(wb_error),
    .line_index(line_index), .line_data(line_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line storage contents for the current writeback
  logic [31:0] mem [16];
  assign line_data = mem[line_index];

  // Responder configuration
  int         aw_delay = 0;
  int         w_pct    = 100;
  int         b_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int         aw_cnt = 0;
  int         b_cnt  = 0;

  // Memory-side responder: ready/valid updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (awvalid) aw_cnt++; else aw_cnt = 0;
    awready = awvalid && (aw_cnt > aw_delay);
    wready  = ($urandom_range(99) < w_pct);
    if (bready) b_cnt++; else b_cnt = 0;
    bvalid  = bready && (b_cnt > b_delay);
    bresp   = bvalid ? bresp_cfg : 2'b00;
  end

  // Observed transactions
  logic [31:0] aw_q[$];
  logic [7:0]  awlen_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wi_q[$];
  logic        wl_q[$];
  int          done_cnt = 0;
  logic        aw_seen = 1'b0;
  logic        prev_stall = 1'b0;
  logic [3:0]  prev_idx;
  logic [31:0] prev_data;

  // Bus monitor, sampled mid-cycle where handshakes reflect the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && wvalid) begin
        chk("stall_idx", 64'(line_index), 64'(prev_idx));
        chk("stall_data", 64'(wdata), 64'(prev_data));
      end
      if (wvalid) chk("w_after_aw", 64'(aw_seen), 64'd1);
      if (awvalid && awready && wready) chk("simul_no_w", 64'(wvalid), 64'd0);
      if (awvalid && awready) begin
        aw_q.push_back(awaddr);
        awlen_q.push_back(awlen);
        aw_seen = 1'b1;
      end
      if (wvalid && wready) begin
        wd_q.push_back(wdata);
        wi_q.push_back(line_index);
        wl_q.push_back(wlast);
      end
      if (wb_done) done_cnt++;
      prev_stall = wvalid && !wready;
      prev_idx   = line_index;
      prev_data  = wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_obs();
    aw_q.delete(); awlen_q.delete(); wd_q.delete(); wi_q.delete(); wl_q.delete();
    done_cnt = 0;
    aw_seen  = 1'b0;
  endtask

  task automatic fill_line();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endtask

  task automatic pulse_start(input logic [19:0] t, input logic [5:0] l);
    @(posedge clk); #1;
    wb_tag = t; wb_line = l; wb_start = 1'b1;
    @(posedge clk); #1;
    wb_start = 1'b0;
  endtask

  // Compare a completed writeback against the line contents and target address
  task automatic check_burst(input string name, input logic [19:0] t, input logic [5:0] l);
    logic [31:0] exp_addr;
    exp_addr = (32'(t) << 12) | (32'(l) << 6);
    chk({name, "_aw_count"}, 64'(aw_q.size()), 64'd1);
    if (aw_q.size() > 0) begin
      chk({name, "_awaddr"}, 64'(aw_q[0]), 64'(exp_addr));
      chk({name, "_awlen"}, 64'(awlen_q[0]), 64'd15);
    end
    chk({name, "_beats"}, 64'(wd_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < wd_q.size(); i++) begin
      chk({name, "_wdata"}, 64'(wd_q[i]), 64'(mem[i]));
      chk({name, "_widx"}, 64'(wi_q[i]), 64'(i));
      chk({name, "_wlast"}, 64'(wl_q[i]), 64'(i == 15));
    end
  endtask

  // One writeback; optional extra start after a given beat count and in the done cycle
  task automatic run_wb(input string name, input logic [19:0] t, input logic [5:0] l,
                        input logic exp_err, input int extra_beat);
    bit done;
    bit extra_sent;
    clear_obs();
    fill_line();
    pulse_start(t, l);
    chk({name, "_busy_1cyc"}, 64'(wb_busy), 64'd1);
    chk({name, "_awvalid_1cyc"}, 64'(awvalid), 64'd1);
    done = 0;
    extra_sent = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      wb_start = 1'b0;
      if (wb_done) begin
        done = 1;
        chk({name, "_error"}, 64'(wb_error), 64'(exp_err));
        chk({name, "_busy_at_done"}, 64'(wb_busy), 64'd0);
        wb_tag = ~t; wb_line = ~l; wb_start = 1'b1;
      end else if (extra_beat >= 0 && !extra_sent && wd_q.size() >= extra_beat) begin
        extra_sent = 1;
        wb_tag = ~t; wb_line = ~l; wb_start = 1'b1;
      end
    end
    if (!done) chk({name, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    wb_start = 1'b0;
    chk({name, "_done_pulse"}, 64'(wb_done), 64'd0);
    chk({name, "_idle_after"}, 64'(wb_busy), 64'd0);
    chk({name, "_error_holds"}, 64'(wb_error), 64'(exp_err));
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({name, "_no_restart"}, 64'(awvalid), 64'd0);
    check_burst(name, t, l);
  endtask

  initial begin
    rst = 1'b1; wb_start = 1'b0; wb_tag = '0; wb_line = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_busy", 64'(wb_busy), 64'd0);
    chk("rst_done", 64'(wb_done), 64'd0);
    chk("rst_error", 64'(wb_error), 64'd0);
    chk("rst_index", 64'(line_index), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("const_awsize", 64'(awsize), 64'd2);
    chk("const_awburst", 64'(awburst), 64'd1);
    chk("const_wstrb", 64'(wstrb), 64'hf);
    rst = 1'b0;

    // Basic: everything always ready (also covers AW and W ready together)
    aw_delay = 0; w_pct = 100; b_delay = 0; bresp_cfg = 2'b00;
    run_wb("basic", 20'h12345, 6'd5, 1'b0, -1);

    // Backpressure: delayed AW and random W stalls
    aw_delay = 7; w_pct = 50; b_delay = 3;
    run_wb("bp", 20'($urandom), 6'($urandom), 1'b0, -1);

    // Error response, then a clean writeback clears it
    aw_delay = 1; w_pct = 70; b_delay = 0; bresp_cfg = 2'b10;
    run_wb("err", 20'($urandom), 6'($urandom), 1'b1, -1);
    bresp_cfg = 2'b00;
    run_wb("clean", 20'($urandom), 6'($urandom), 1'b0, -1);

    // Start while busy, issued mid-DATA
    aw_delay = 2; w_pct = 60; b_delay = 2;
    run_wb("busy_start", 20'($urandom), 6'($urandom), 1'b0, 5);

    // Reset mid-burst after beat 6
    begin
      bit hit;
      clear_obs();
      fill_line();
      aw_delay = 0; w_pct = 100; b_delay = 0;
      pulse_start(20'hABCDE, 6'd9);
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(posedge clk); #1;
        if (wd_q.size() >= 6) hit = 1;
      end
      if (!hit) chk("rst_mid_timeout", 64'd0, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstm_wvalid", 64'(wvalid), 64'd0);
      chk("rstm_awvalid", 64'(awvalid), 64'd0);
      chk("rstm_bready", 64'(bready), 64'd0);
      chk("rstm_busy", 64'(wb_busy), 64'd0);
      chk("rstm_index", 64'(line_index), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("rstm_no_done", 64'(done_cnt), 64'd0);
      chk("rstm_still_idle", 64'(wb_busy), 64'd0);
    end
    run_wb("after_rst", 20'($urandom), 6'($urandom), 1'b0, -1);

    // A few fully random writebacks
    for (int k = 0; k < 4; k++) begin
      aw_delay = $urandom_range(4); w_pct = 30 + $urandom_range(70); b_delay = $urandom_range(5);
      bresp_cfg = 2'($urandom_range(3));
      run_wb("rand", 20'($urandom), 6'($urandom), (bresp_cfg != 2'b00), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
